// File: rtl/timer_pkg.sv
// Shared state encoding, BCD digit limits and 00..59 BCD field arithmetic
// used by the MM:SS countdown timer.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      ALARM = 2'd3
   } state_t;

   localparam logic [3:0] TENS_MAX = 4'd5;
   localparam logic [3:0] ONES_MAX = 4'd9;

   // +1 on a {tens, ones} field, 59 wraps to 00
   function automatic logic [7:0] bcd60_inc(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] >= ONES_MAX) begin
         r[3:0] = 4'd0;
         r[7:4] = (v[7:4] >= TENS_MAX) ? 4'd0 : (v[7:4] + 4'd1);
      end else begin
         r[3:0] = v[3:0] + 4'd1;
         r[7:4] = v[7:4];
      end
      return r;
   endfunction

   // Conditional -1 on a {tens, ones} field; result is {borrow_out, field}
   function automatic logic [8:0] bcd60_dec(input logic [7:0] v, input logic borrow_in);
      logic [8:0] r;
      if (!borrow_in) begin
         r = {1'b0, v};
      end else if (v[3:0] != 4'd0) begin
         r = {1'b0, v[7:4], v[3:0] - 4'd1};
      end else if (v[7:4] != 4'd0) begin
         r = {1'b0, v[7:4] - 4'd1, ONES_MAX};
      end else begin
         r = {1'b1, TENS_MAX, ONES_MAX};
      end
      return r;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 while enabled, held at 0 otherwise, and
// flags the last count of each period with a one-cycle tick.
module tick_gen #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_r;

   // Period counter, cleared whenever the timer is not counting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (!en) begin
         cnt_r <= '0;
      end else if (cnt_r == LAST) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + CW'(1);
      end
   end

   assign tick = en && (cnt_r == LAST);

endmodule

// File: rtl/countdown_timer_bcd.sv
// MM:SS BCD countdown timer with pause/resume and a self-clearing alarm phase
// that lasts ALARM_SECS ticks.
module countdown_timer_bcd
   import timer_pkg::*;
#(
   parameter int TICK_DIV   = 50_000_000,
   parameter int ALARM_SECS = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       inc_min,
   input  logic       inc_sec,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running,
   output logic       alarm
);

   localparam int AW = $clog2(ALARM_SECS + 1);
   localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECS - 1);

   state_t        state_r, state_s;
   logic [7:0]    min_r, min_s, sec_r, sec_s;
   logic [AW-1:0] acnt_r, acnt_s;
   logic          running_r, alarm_r;
   logic          tick_s, tick_en_s;
   logic [8:0]    dec_sec_s, dec_min_s;
   logic          dec_zero_s;

   assign tick_en_s = (state_r == RUN) || (state_r == ALARM);

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (tick_en_s),
      .tick (tick_s)
   );

   // Seconds always borrow; minutes only when seconds wrapped past 00
   assign dec_sec_s  = bcd60_dec(sec_r, 1'b1);
   assign dec_min_s  = bcd60_dec(min_r, dec_sec_s[8]);
   assign dec_zero_s = ({dec_min_s[7:0], dec_sec_s[7:0]} == 16'd0);

   // Next-state and next-digit logic; clear > start_stop > increments
   always_comb begin
      state_s = state_r;
      min_s   = min_r;
      sec_s   = sec_r;
      acnt_s  = acnt_r;
      case (state_r)
         IDLE: begin
            if (clear) begin
               min_s = 8'd0;
               sec_s = 8'd0;
            end else if (start_stop) begin
               state_s = ({min_r, sec_r} != 16'd0) ? RUN : IDLE;
            end else begin
               min_s = inc_min ? bcd60_inc(min_r) : min_r;
               sec_s = inc_sec ? bcd60_inc(sec_r) : sec_r;
            end
         end
         RUN: begin
            if (clear) begin
               state_s = IDLE;
               min_s   = 8'd0;
               sec_s   = 8'd0;
            end else if (tick_s) begin
               min_s = dec_min_s[7:0];
               sec_s = dec_sec_s[7:0];
               if (dec_zero_s) begin
                  state_s = ALARM;
               end else begin
                  state_s = start_stop ? PAUSE : RUN;
               end
            end else begin
               state_s = start_stop ? PAUSE : RUN;
            end
         end
         PAUSE: begin
            if (clear) begin
               state_s = IDLE;
               min_s   = 8'd0;
               sec_s   = 8'd0;
            end else begin
               state_s = start_stop ? RUN : PAUSE;
            end
         end
         ALARM: begin
            min_s = 8'd0;
            sec_s = 8'd0;
            if (clear || start_stop) begin
               state_s = IDLE;
               acnt_s  = '0;
            end else if (tick_s) begin
               if (acnt_r == ALARM_LAST) begin
                  state_s = IDLE;
                  acnt_s  = '0;
               end else begin
                  acnt_s = acnt_r + AW'(1);
               end
            end else begin
               acnt_s = acnt_r;
            end
         end
         default: begin
            state_s = IDLE;
            min_s   = 8'd0;
            sec_s   = 8'd0;
            acnt_s  = '0;
         end
      endcase
   end

   // State, digit and flag registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         min_r     <= 8'd0;
         sec_r     <= 8'd0;
         acnt_r    <= '0;
         running_r <= 1'b0;
         alarm_r   <= 1'b0;
      end else begin
         state_r   <= state_s;
         min_r     <= min_s;
         sec_r     <= sec_s;
         acnt_r    <= acnt_s;
         running_r <= (state_s == RUN);
         alarm_r   <= (state_s == ALARM);
      end
   end

   assign min_tens = min_r[7:4];
   assign min_ones = min_r[3:0];
   assign sec_tens = sec_r[7:4];
   assign sec_ones = sec_r[3:0];
   assign running  = running_r;
   assign alarm    = alarm_r;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Self-checking bench: directed vector table, async-reset sequences and a
// randomized run compared against a seconds-based reference model.
module tb_countdown_timer_bcd;

   localparam int TD = 4;
   localparam int AS = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_stop = 1'b0;
   logic       clear = 1'b0;
   logic       inc_min = 1'b0;
   logic       inc_sec = 1'b0;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       running, alarm;

   countdown_timer_bcd #(.TICK_DIV(TD), .ALARM_SECS(AS)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_stop (start_stop),
      .clear      (clear),
      .inc_min    (inc_min),
      .inc_sec    (inc_sec),
      .min_tens   (min_tens),
      .min_ones   (min_ones),
      .sec_tens   (sec_tens),
      .sec_ones   (sec_ones),
      .running    (running),
      .alarm      (alarm)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: mode 0 idle, 1 run, 2 pause, 3 alarm; time as total seconds
   int m_mode, m_secs, m_pre, m_acnt;

   typedef struct {
      logic ss; logic cl; logic im; logic isc;
      int   n;  int   mm; int   sc;
      logic run; logic al;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_secs = 0; m_pre = 0; m_acnt = 0;
   endtask

   task automatic model_step(input logic ss, input logic cl, input logic im, input logic isc);
      bit counting;
      bit tick;
      int mm, s;
      counting = (m_mode == 1) || (m_mode == 3);
      tick     = counting && (m_pre == TD - 1);
      m_pre    = counting ? (m_pre + 1) % TD : 0;
      case (m_mode)
         0: begin
            if (cl) m_secs = 0;
            else if (ss) begin
               if (m_secs != 0) m_mode = 1;
            end else begin
               mm = m_secs / 60;
               s  = m_secs % 60;
               if (im) mm = (mm + 1) % 60;
               if (isc) s = (s + 1) % 60;
               m_secs = mm * 60 + s;
            end
         end
         1: begin
            if (cl) begin m_mode = 0; m_secs = 0; end
            else if (tick) begin
               m_secs = m_secs - 1;
               if (m_secs == 0) m_mode = 3;
               else if (ss) m_mode = 2;
            end else if (ss) m_mode = 2;
         end
         2: begin
            if (cl) begin m_mode = 0; m_secs = 0; end
            else if (ss) m_mode = 1;
         end
         default: begin
            if (cl || ss) begin m_mode = 0; m_acnt = 0; end
            else if (tick) begin
               m_acnt = m_acnt + 1;
               if (m_acnt == AS) begin m_mode = 0; m_acnt = 0; end
            end
         end
      endcase
   endtask

   task automatic check_model();
      check("model min_tens", min_tens, (m_secs / 60) / 10);
      check("model min_ones", min_ones, (m_secs / 60) % 10);
      check("model sec_tens", sec_tens, (m_secs % 60) / 10);
      check("model sec_ones", sec_ones, (m_secs % 60) % 10);
      check("model running",  running,  (m_mode == 1) ? 1 : 0);
      check("model alarm",    alarm,    (m_mode == 3) ? 1 : 0);
   endtask

   task automatic cycle(input logic ss, input logic cl, input logic im, input logic isc);
      start_stop = ss; clear = cl; inc_min = im; inc_sec = isc;
      @(posedge clk);
      model_step(ss, cl, im, isc);
      #1;
      check_model();
      start_stop = 1'b0; clear = 1'b0; inc_min = 1'b0; inc_sec = 1'b0;
   endtask

   task automatic add(input logic ss, input logic cl, input logic im, input logic isc,
                      input int n, input int mm, input int sc, input logic run, input logic al);
      vec_t v;
      v.ss = ss; v.cl = cl; v.im = im; v.isc = isc;
      v.n = n; v.mm = mm; v.sc = sc; v.run = run; v.al = al;
      vecs.push_back(v);
   endtask

   task automatic async_reset_check(input string tag);
      #2;
      rst = 1'b1;
      #1;
      check({tag, " min_tens"}, min_tens, 0);
      check({tag, " min_ones"}, min_ones, 0);
      check({tag, " sec_tens"}, sec_tens, 0);
      check({tag, " sec_ones"}, sec_ones, 0);
      check({tag, " running"},  running,  0);
      check({tag, " alarm"},    alarm,    0);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset min_tens", min_tens, 0);
      check("reset sec_ones", sec_ones, 0);
      check("reset running",  running,  0);
      check("reset alarm",    alarm,    0);
      rst = 1'b0;

      //  ss cl im is   n   mm sc run al
      add(0, 0, 0, 0,  1,  0, 0, 0, 0);
      add(1, 0, 0, 0,  1,  0, 0, 0, 0);
      add(0, 0, 0, 1, 61,  0, 1, 0, 0);
      add(0, 0, 1, 0, 60,  0, 1, 0, 0);
      add(0, 0, 1, 0,  2,  2, 1, 0, 0);
      add(0, 0, 1, 1,  1,  3, 2, 0, 0);
      add(0, 1, 0, 0,  1,  0, 0, 0, 0);
      add(0, 0, 1, 0,  1,  1, 0, 0, 0);
      add(1, 0, 0, 0,  1,  1, 0, 1, 0);
      add(0, 0, 0, 0,  4,  0,59, 1, 0);
      add(0, 0, 1, 1,  4,  0,58, 1, 0);
      add(1, 0, 0, 0,  1,  0,58, 0, 0);
      add(0, 0, 0, 0, 20,  0,58, 0, 0);
      add(0, 0, 1, 1,  1,  0,58, 0, 0);
      add(1, 0, 0, 0,  1,  0,58, 1, 0);
      add(0, 0, 0, 0,  3,  0,58, 1, 0);
      add(0, 0, 0, 0,  1,  0,57, 1, 0);
      add(0, 1, 0, 0,  1,  0, 0, 0, 0);
      add(0, 0, 0, 1,  2,  0, 2, 0, 0);
      add(1, 0, 0, 0,  1,  0, 2, 1, 0);
      add(0, 0, 0, 0,  4,  0, 1, 1, 0);
      add(0, 0, 0, 0,  3,  0, 1, 1, 0);
      add(0, 0, 0, 0,  1,  0, 0, 0, 1);
      add(0, 0, 0, 0, 11,  0, 0, 0, 1);
      add(0, 0, 0, 0,  1,  0, 0, 0, 0);
      add(0, 0, 0, 1,  1,  0, 1, 0, 0);
      add(1, 0, 0, 0,  1,  0, 1, 1, 0);
      add(0, 0, 0, 0,  3,  0, 1, 1, 0);
      add(0, 0, 0, 0,  1,  0, 0, 0, 1);
      add(0, 0, 0, 0,  2,  0, 0, 0, 1);
      add(1, 0, 0, 0,  1,  0, 0, 0, 0);
      add(0, 0, 1, 0,  3,  3, 0, 0, 0);
      add(1, 1, 0, 0,  1,  0, 0, 0, 0);
      add(0, 0, 0, 0,  1,  0, 0, 0, 0);
      add(0, 0, 0, 1,  1,  0, 1, 0, 0);
      add(1, 0, 0, 0,  1,  0, 1, 1, 0);
      add(0, 0, 0, 0,  3,  0, 1, 1, 0);
      add(1, 0, 0, 0,  1,  0, 0, 0, 1);
      add(0, 1, 0, 0,  1,  0, 0, 0, 0);
      add(0, 0, 0, 1,  5,  0, 5, 0, 0);
      add(1, 0, 0, 0,  1,  0, 5, 1, 0);
      add(0, 0, 0, 0,  3,  0, 5, 1, 0);
      add(1, 0, 0, 0,  1,  0, 4, 0, 0);
      add(0, 0, 0, 0,  8,  0, 4, 0, 0);
      add(0, 1, 0, 0,  1,  0, 0, 0, 0);

      foreach (vecs[k]) begin
         repeat (vecs[k].n) cycle(vecs[k].ss, vecs[k].cl, vecs[k].im, vecs[k].isc);
         check($sformatf("vec%0d minutes", k), min_tens * 10 + min_ones, vecs[k].mm);
         check($sformatf("vec%0d seconds", k), sec_tens * 10 + sec_ones, vecs[k].sc);
         check($sformatf("vec%0d running", k), running, vecs[k].run);
         check($sformatf("vec%0d alarm", k),   alarm,   vecs[k].al);
      end

      // Async reset while counting down from 05:00
      repeat (5) cycle(0, 0, 1, 0);
      cycle(1, 0, 0, 0);
      repeat (6) cycle(0, 0, 0, 0);
      check("pre-rst running", running, 1);
      async_reset_check("rst mid-run");

      // Async reset in the middle of the alarm phase
      cycle(0, 0, 0, 1);
      cycle(1, 0, 0, 0);
      repeat (5) cycle(0, 0, 0, 0);
      check("pre-rst alarm", alarm, 1);
      async_reset_check("rst mid-alarm");

      // Randomized traffic against the reference model
      for (int i = 0; i < 4000; i++) begin
         logic ss, cl, im, isc;
         cl  = ($urandom_range(0, 49) == 0);
         ss  = ($urandom_range(0, 11) == 0);
         im  = ($urandom_range(0, 19) == 0);
         isc = ($urandom_range(0, 5) == 0);
         cycle(ss, cl, im, isc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
